pcc_rx_endpoint: RTL and testbench

Parametrised receive endpoint between the PCC router's local output port and the IP core. It decodes incoming flits and buffers packet payloads in a DEPTH-entry FIFO with commit/rewind pointers, so the IP only ever sees complete packets. It returns pack, cancel, fail and suspend status to the network. It replaces the fixed edge-detect receiver: fail and suspend are now real, cancelled or overflowed packets are discarded, and width, depth and threshold are parameters.

---
 rtl/pcc_rx_endpoint.sv | 160 ++++++++++++++++
 tb/tb_pcc_rx_endpoint.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pcc_rx_endpoint.sv
// Receive endpoint between the PCC router local port and the IP core.
// Packets are staged in a FIFO with commit/rewind pointers so the IP only sees complete packets.
module pcc_rx_endpoint #(
    parameter int DATAW   = 66,
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int SUSP_TH = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATAW-1:0]   PCC_ip_data_i,
    input  logic               PCC_ip_stb_i,
    input  logic               PCC_ip_fwd_i,
    output logic               PCC_ip_fail_o,
    output logic               PCC_ip_pack_o,
    output logic               PCC_ip_suspend_o,
    output logic               PCC_ip_cancel_o,
    output logic [DATAW-4:0]   rd_data_o,
    output logic               rd_last_o,
    output logic               rd_valid_o,
    input  logic               rd_ready_i,
    output logic [AW:0]        level_o
);

    localparam int PW = DATAW - 3;
    localparam int EW = DATAW - 2;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] SUSP_W  = (AW+1)'(SUSP_TH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wr_q, wr_d, cmt_q, cmt_d, rd_q, rd_d;
    logic [1:0]    state_q, state_d;
    logic          pack_q, pack_d, fail_q, fail_d, cancel_q, cancel_d, susp_q;
    logic          we, do_head;
    logic [AW:0]   waddr;

    logic          acc, f_head, is_cancel, is_tail, full, cmt_full, rd_fire;
    logic [AW:0]   used, cmt_used;
    logic [EW-1:0] rd_entry;

    assign acc       = PCC_ip_stb_i & ~PCC_ip_fwd_i;
    assign f_head    = PCC_ip_data_i[DATAW-1];
    assign is_cancel = (PCC_ip_data_i[DATAW-2:DATAW-3] == 2'b11);
    assign is_tail   = (PCC_ip_data_i[DATAW-2:DATAW-3] == 2'b01);
    assign used      = wr_q - rd_q;
    assign cmt_used  = cmt_q - rd_q;
    assign full      = (used == DEPTH_W);
    // A new head always starts from the commit point, even when it interrupts a packet.
    assign cmt_full  = (cmt_used == DEPTH_W);

    always_comb begin
        wr_d     = wr_q;
        cmt_d    = cmt_q;
        state_d  = state_q;
        pack_d   = 1'b0;
        fail_d   = 1'b0;
        cancel_d = 1'b0;
        we       = 1'b0;
        waddr    = wr_q;
        do_head  = 1'b0;
        if (acc) begin
            case (state_q)
                ST_RECV: begin
                    if (is_cancel) begin
                        wr_d     = cmt_q;
                        cancel_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else if (f_head) begin
                        fail_d  = 1'b1;
                        do_head = 1'b1;
                    end else if (full) begin
                        wr_d    = cmt_q;
                        fail_d  = 1'b1;
                        state_d = is_tail ? ST_IDLE : ST_DROP;
                    end else begin
                        we   = 1'b1;
                        wr_d = wr_q + 1'b1;
                        if (is_tail) begin
                            cmt_d   = wr_q + 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    if (is_cancel) begin
                        cancel_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else if (f_head) begin
                        do_head = 1'b1;
                    end else if (state_q == ST_DROP && is_tail) begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
        if (do_head) begin
            wr_d = cmt_q;
            if (cmt_full) begin
                fail_d  = 1'b1;
                state_d = is_tail ? ST_IDLE : ST_DROP;
            end else begin
                we     = 1'b1;
                waddr  = cmt_q;
                wr_d   = cmt_q + 1'b1;
                pack_d = 1'b1;
                if (is_tail) begin
                    cmt_d   = cmt_q + 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RECV;
                end
            end
        end
    end

    assign rd_valid_o = (rd_q != cmt_q);
    assign rd_fire    = rd_valid_o & rd_ready_i;
    assign rd_d       = rd_q + (AW+1)'(rd_fire);

    always_ff @(posedge clk) begin
        if (we) mem[waddr[AW-1:0]] <= {is_tail, PCC_ip_data_i[PW-1:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q     <= '0;
            cmt_q    <= '0;
            rd_q     <= '0;
            state_q  <= ST_IDLE;
            pack_q   <= 1'b0;
            fail_q   <= 1'b0;
            cancel_q <= 1'b0;
            susp_q   <= 1'b0;
        end else begin
            wr_q     <= wr_d;
            cmt_q    <= cmt_d;
            rd_q     <= rd_d;
            state_q  <= state_d;
            pack_q   <= pack_d;
            fail_q   <= fail_d;
            cancel_q <= cancel_d;
            susp_q   <= (used >= SUSP_W);
        end
    end

    // Head data is masked while empty so outputs read 0 out of reset.
    assign rd_entry         = mem[rd_q[AW-1:0]];
    assign rd_data_o        = rd_valid_o ? rd_entry[PW-1:0] : '0;
    assign rd_last_o        = rd_valid_o & rd_entry[EW-1];
    assign level_o          = used;
    assign PCC_ip_pack_o    = pack_q;
    assign PCC_ip_fail_o    = fail_q;
    assign PCC_ip_cancel_o  = cancel_q;
    assign PCC_ip_suspend_o = susp_q;

endmodule

// File: tb/tb_pcc_rx_endpoint.sv
// Directed bench for pcc_rx_endpoint: single/multi-flit packets, cancel, overflow,
// interrupted packet, forwarded flits and mid-packet reset.
module tb_pcc_rx_endpoint;
    localparam int DATAW = 66;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATAW-1:0]  data;
    logic              stb, fwd, rd_ready;
    logic              fail, pack, susp, cancel, rd_last, rd_valid;
    logic [DATAW-4:0]  rd_data;
    logic [4:0]        level;
    int                total = 0;
    int                bad = 0;

    always #5 clk = ~clk;

    pcc_rx_endpoint #(.DATAW(66), .DEPTH(16), .AW(4), .SUSP_TH(12)) dut (
        .clk(clk), .reset(reset),
        .PCC_ip_data_i(data), .PCC_ip_stb_i(stb), .PCC_ip_fwd_i(fwd),
        .PCC_ip_fail_o(fail), .PCC_ip_pack_o(pack),
        .PCC_ip_suspend_o(susp), .PCC_ip_cancel_o(cancel),
        .rd_data_o(rd_data), .rd_last_o(rd_last), .rd_valid_o(rd_valid),
        .rd_ready_i(rd_ready), .level_o(level)
    );

    function automatic logic [DATAW-1:0] mk(input logic h, input logic [1:0] c, input logic [62:0] p);
        return {h, c, p};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [DATAW-1:0] f, input logic fw);
        @(negedge clk);
        data = f; stb = 1'b1; fwd = fw;
        @(posedge clk); #1;
        stb = 1'b0; fwd = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [62:0] exp_d, input logic exp_l);
        chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
        chk({tag, "_data"}, 64'(rd_data), 64'(exp_d));
        chk({tag, "_last"}, 64'(rd_last), 64'(exp_l));
        @(negedge clk);
        rd_ready = 1'b1;
        @(posedge clk); #1;
        rd_ready = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_pack"}, 64'(pack), 64'd0);
        chk({tag, "_fail"}, 64'(fail), 64'd0);
        chk({tag, "_cancel"}, 64'(cancel), 64'd0);
        chk({tag, "_susp"}, 64'(susp), 64'd0);
        chk({tag, "_valid"}, 64'(rd_valid), 64'd0);
        chk({tag, "_data"}, 64'(rd_data), 64'd0);
        chk({tag, "_last"}, 64'(rd_last), 64'd0);
        chk({tag, "_level"}, 64'(level), 64'd0);
    endtask

    initial begin
        reset = 1'b1; data = '0; stb = 1'b0; fwd = 1'b0; rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_zero_outputs("reset");

        // single-flit packet with reader ready
        rd_ready = 1'b1;
        send(mk(1'b1, 2'b01, 63'h5), 1'b0);
        chk("t1_pack", 64'(pack), 64'd1);
        chk("t1_fail", 64'(fail), 64'd0);
        chk("t1_cancel", 64'(cancel), 64'd0);
        chk("t1_valid", 64'(rd_valid), 64'd1);
        chk("t1_data", 64'(rd_data), 64'h5);
        chk("t1_last", 64'(rd_last), 64'd1);
        idle_cycle();
        rd_ready = 1'b0;
        chk("t1_pack_off", 64'(pack), 64'd0);
        chk("t1_consumed", 64'(rd_valid), 64'd0);
        chk("t1_level", 64'(level), 64'd0);

        // 4-flit packet held until tail
        send(mk(1'b1, 2'b00, 63'h11), 1'b0);
        chk("t2_pack", 64'(pack), 64'd1);
        chk("t2_valid_h", 64'(rd_valid), 64'd0);
        send(mk(1'b0, 2'b00, 63'h22), 1'b0);
        chk("t2_pack_b", 64'(pack), 64'd0);
        send(mk(1'b0, 2'b10, 63'h33), 1'b0);
        chk("t2_valid_b", 64'(rd_valid), 64'd0);
        chk("t2_level_b", 64'(level), 64'd3);
        send(mk(1'b0, 2'b01, 63'h44), 1'b0);
        chk("t2_valid_t", 64'(rd_valid), 64'd1);
        chk("t2_level", 64'(level), 64'd4);
        pop("t2_p0", 63'h11, 1'b0);
        pop("t2_p1", 63'h22, 1'b0);
        pop("t2_p2", 63'h33, 1'b0);
        pop("t2_p3", 63'h44, 1'b1);
        chk("t2_empty", 64'(rd_valid), 64'd0);

        // cancel mid-packet, then a good packet
        send(mk(1'b1, 2'b00, 63'h61), 1'b0);
        send(mk(1'b0, 2'b00, 63'h62), 1'b0);
        send(mk(1'b0, 2'b00, 63'h63), 1'b0);
        chk("t3_level_pre", 64'(level), 64'd3);
        send(mk(1'b0, 2'b11, 63'h0), 1'b0);
        chk("t3_cancel", 64'(cancel), 64'd1);
        chk("t3_level", 64'(level), 64'd0);
        chk("t3_valid", 64'(rd_valid), 64'd0);
        send(mk(1'b1, 2'b00, 63'h77), 1'b0);
        chk("t3_cancel_off", 64'(cancel), 64'd0);
        send(mk(1'b0, 2'b01, 63'h78), 1'b0);
        pop("t3_p0", 63'h77, 1'b0);
        pop("t3_p1", 63'h78, 1'b1);

        // 20-flit packet overflows a 16-entry buffer
        for (int i = 1; i <= 20; i++) begin
            send(mk(i == 1, (i == 20) ? 2'b01 : 2'b00, 63'(i)), 1'b0);
            if (i == 1)  chk("t4_pack", 64'(pack), 64'd1);
            if (i == 11) chk("t4_susp_lo", 64'(susp), 64'd0);
            if (i == 13) chk("t4_susp_hi", 64'(susp), 64'd1);
            if (i == 16) begin
                chk("t4_level16", 64'(level), 64'd16);
                chk("t4_nofail16", 64'(fail), 64'd0);
            end
            if (i == 17) begin
                chk("t4_fail", 64'(fail), 64'd1);
                chk("t4_level_rw", 64'(level), 64'd0);
            end
            if (i == 18) chk("t4_fail_off", 64'(fail), 64'd0);
            if (i == 20) begin
                chk("t4_level_end", 64'(level), 64'd0);
                chk("t4_pack_end", 64'(pack), 64'd0);
                chk("t4_valid_end", 64'(rd_valid), 64'd0);
                chk("t4_susp_end", 64'(susp), 64'd0);
            end
        end
        send(mk(1'b1, 2'b01, 63'h9), 1'b0);
        chk("t4_after_pack", 64'(pack), 64'd1);
        pop("t4_after", 63'h9, 1'b1);

        // head arrives while a packet is open
        send(mk(1'b1, 2'b00, 63'hA1), 1'b0);
        send(mk(1'b0, 2'b00, 63'hA2), 1'b0);
        send(mk(1'b1, 2'b00, 63'hB1), 1'b0);
        chk("t5_fail", 64'(fail), 64'd1);
        chk("t5_pack", 64'(pack), 64'd1);
        chk("t5_level", 64'(level), 64'd1);
        send(mk(1'b0, 2'b01, 63'hB2), 1'b0);
        chk("t5_fail_off", 64'(fail), 64'd0);
        chk("t5_level2", 64'(level), 64'd2);
        pop("t5_p0", 63'hB1, 1'b0);
        pop("t5_p1", 63'hB2, 1'b1);
        chk("t5_empty", 64'(rd_valid), 64'd0);

        // forwarded flits are invisible
        send(mk(1'b1, 2'b00, 63'hC1), 1'b1);
        chk("t6_fwd_pack", 64'(pack), 64'd0);
        send(mk(1'b0, 2'b00, 63'hC2), 1'b1);
        send(mk(1'b0, 2'b01, 63'hC3), 1'b1);
        chk("t6_fwd_level", 64'(level), 64'd0);
        chk("t6_fwd_valid", 64'(rd_valid), 64'd0);
        idle_cycle();
        chk_zero_outputs("t6_fwd");

        // reset in the middle of a packet
        send(mk(1'b1, 2'b00, 63'hD1), 1'b0);
        send(mk(1'b0, 2'b00, 63'hD2), 1'b0);
        chk("t6_level_pre", 64'(level), 64'd2);
        do_reset();
        chk_zero_outputs("t6_rst");
        send(mk(1'b1, 2'b01, 63'hE1), 1'b0);
        chk("t6_post_pack", 64'(pack), 64'd1);
        pop("t6_post", 63'hE1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
